alu_mdu_seq: RTL

- Iterative unsigned multiply/divide sequencer that reuses the shared 32-bit combinational ALU.
- Drives the ALU's OP/A/B each cycle and consumes its F and CF: one ALU ADD or SUB per iteration, 32 iterations per operation.
- Sits beside the execute stage. The pipeline hands it MUL/MULHU/DIVU/REMU through a valid/ready pair and waits for the result.

---
 rtl/alu_pkg.sv | 10 +
 rtl/alu_mdu_seq.sv | 96 +++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, MDU operation codes and sequencer state encoding.
package alu_pkg;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b0001;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b1101;
    typedef enum logic [1:0] {MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU} mdu_op_t;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: iterative unsigned multiply/divide that borrows the shared ALU for one
// ADD or SUB per step. hi/lo/mc double as r/q/d while dividing.
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    input  logic            flush,
    output logic            busy,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_f,
    input  logic            alu_cf
);
    state_t state, next_state;
    mdu_op_t op;
    logic [XLEN-1:0] hi, lo, mc, hi_n, lo_n, s;
    logic [CNT_W-1:0] cnt;
    logic is_div, ok, last, in_div, div0;

    assign is_div    = op[1];
    assign in_div    = in_op[1];
    assign div0      = in_div && in_b == '0;
    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_DONE;
    assign busy      = state == S_BUSY;
    assign last      = cnt == CNT_W'(XLEN - 1);
    assign s         = {hi[XLEN-2:0], lo[XLEN-1]};
    assign ok        = hi[XLEN-1] | ~alu_cf;
    assign alu_op    = busy && is_div ? ALU_SUB : ALU_ADD;
    assign alu_a     = busy ? (is_div ? s : hi) : '0;
    assign alu_b     = busy ? mc : '0;

    always_comb begin
        hi_n = '0;
        lo_n = '0;
        if (is_div) begin
            hi_n = ok ? alu_f : s;
            lo_n = {lo[XLEN-2:0], ok};
        end else begin
            hi_n = lo[0] ? {alu_cf, alu_f[XLEN-1:1]} : {1'b0, hi[XLEN-1:1]};
            lo_n = {lo[0] ? alu_f[0] : hi[0], lo[XLEN-1:1]};
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (in_valid) next_state = div0 ? S_DONE : S_BUSY;
            S_BUSY: if (last) next_state = S_DONE;
            S_DONE: if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (flush) next_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op         <= MDU_MUL;
            hi         <= '0;
            lo         <= '0;
            mc         <= '0;
            cnt        <= '0;
            out_result <= '0;
        end else begin
            state <= next_state;
            if (!flush && state == S_IDLE && in_valid) begin
                op  <= mdu_op_t'(in_op);
                hi  <= '0;
                lo  <= in_div ? in_a : in_b;
                mc  <= in_div ? in_b : in_a;
                cnt <= '0;
                if (div0) out_result <= in_op[0] ? in_a : '1;
            end else if (!flush && state == S_BUSY) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt + 1'b1;
                // MULHU and REMU both take the upper register, MUL and DIVU the lower
                if (last) out_result <= op[0] ? hi_n : lo_n;
            end
        end
    end
endmodule
